// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, drives a combinational-read instruction memory, checks each
// fetch against the PMP execute permission, and hands instructions to decode.
// Optional build macro FETCH_STAT_EN adds saturating fetch/fault counters.
//
// Handshake: out_valid/out_instr/out_pc are held stable from the edge that
// raises out_valid until an edge where out_ready=1 (transfer), or until a
// redirect or reset drops them. out_valid never depends on out_ready
// combinationally.
module fetch_ctrl #(
  parameter int unsigned         ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              pmp_x_ok,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_pc,
  input  logic              fault_ack,
`ifdef FETCH_STAT_EN
  output logic [15:0]       fetch_cnt,
  output logic [7:0]        fault_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_pc_d, fault_pc_d;
  logic [31:0]       out_instr_d;
  logic              out_valid_d, fault_valid_d;
  logic              attempt, bad_fetch;

  // The memory address is the PC register itself, never an input path.
  assign imem_addr = pc_q;
  assign dbg_state = state_q;

  // Next-state and next-output selection; redirect outranks everything but reset.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid;
    out_instr_d   = out_instr;
    out_pc_d      = out_pc;
    fault_valid_d = fault_valid;
    fault_pc_d    = fault_pc;
    attempt       = 1'b0;
    bad_fetch     = (pc_q[1:0] != 2'b00) || !pmp_x_ok;

    if (redirect_valid) begin
      // Any handshake on this edge is accepted; the old PC is not fetched.
      pc_d          = redirect_pc;
      out_valid_d   = 1'b0;
      out_instr_d   = NOP_INSTR;
      fault_valid_d = 1'b0;
      state_d       = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: attempt = !halt;
        S_VALID: begin
          if (out_ready) begin
            if (halt) begin
              out_valid_d = 1'b0;
              out_instr_d = NOP_INSTR;
              state_d     = S_FETCH;
            end else begin
              attempt = 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (fault_ack) fault_valid_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase

      if (attempt) begin
        if (bad_fetch) begin
          fault_valid_d = 1'b1;
          fault_pc_d    = pc_q;
          out_valid_d   = 1'b0;
          out_instr_d   = NOP_INSTR;
          state_d       = S_FAULT;
        end else begin
          out_instr_d = imem_instr;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + ADDR_W'(4);
          state_d     = S_VALID;
        end
      end
    end
  end

  // State, PC and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_pc      <= '0;
      fault_valid <= 1'b0;
      fault_pc    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid   <= out_valid_d;
      out_instr   <= out_instr_d;
      out_pc      <= out_pc_d;
      fault_valid <= fault_valid_d;
      fault_pc    <= fault_pc_d;
    end
  end

`ifdef FETCH_STAT_EN
  logic handshake, fault_entry;

  assign handshake   = out_valid && out_ready;
  assign fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else begin
      if (handshake && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if (fault_entry && (fault_cnt != 8'hFF)) fault_cnt <= fault_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed walk-through plus randomized traffic against a
// behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        pmp_x_ok = 1'b1;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        fault_valid;
  logic [7:0]  fault_pc;
  logic        fault_ack = 1'b0;
  logic [1:0]  dbg_state;
`ifdef FETCH_STAT_EN
  logic [15:0] fetch_cnt;
  logic [7:0]  fault_cnt;
`endif

  logic [31:0] mem [0:63];
  assign imem_instr = mem[imem_addr[7:2]];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pmp_x_ok(pmp_x_ok), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault_valid(fault_valid),
    .fault_pc(fault_pc), .fault_ack(fault_ack),
`ifdef FETCH_STAT_EN
    .fetch_cnt(fetch_cnt), .fault_cnt(fault_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "is an instruction held", "is a fault raised", "is fetch parked"
  // as plain flags and applies the edge rules in priority order.
  bit          model_ok = 0;
  int          m_pc, m_opc, m_fpc;
  bit          m_valid, m_fault, m_parked;
  logic [31:0] m_instr;
  int          m_hs_cnt, m_flt_cnt;

  always @(posedge clk) begin
    bit go;
    if (rst) begin
      model_ok = 1; m_pc = 0; m_opc = 0; m_fpc = 0;
      m_valid = 0; m_fault = 0; m_parked = 0; m_instr = NOP;
      m_hs_cnt = 0; m_flt_cnt = 0;
    end else if (model_ok) begin
      if (m_valid && out_ready && m_hs_cnt < 65535) m_hs_cnt++;
      if (redirect_valid) begin
        m_pc = int'(redirect_pc); m_valid = 0; m_instr = NOP;
        m_fault = 0; m_parked = 0;
      end else if (m_parked) begin
        if (fault_ack) m_fault = 0;
      end else begin
        go = m_valid ? (out_ready && !halt) : !halt;
        if (m_valid && out_ready && halt) begin
          m_valid = 0; m_instr = NOP;
        end
        if (go) begin
          if ((m_pc % 4) != 0 || !pmp_x_ok) begin
            m_fault = 1; m_fpc = m_pc; m_parked = 1; m_valid = 0; m_instr = NOP;
            if (m_flt_cnt < 255) m_flt_cnt++;
          end else begin
            m_instr = mem[m_pc / 4]; m_opc = m_pc; m_valid = 1;
            m_pc = (m_pc + 4) % 256;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok && !rst) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("out_instr", out_instr, m_instr);
      if (m_valid) chk("out_pc", {24'b0, out_pc}, m_opc);
      chk("fault_valid", {31'b0, fault_valid}, {31'b0, m_fault});
      if (m_fault) chk("fault_pc", {24'b0, fault_pc}, m_fpc);
      chk("imem_addr", {24'b0, imem_addr}, m_pc);
`ifdef FETCH_STAT_EN
      chk("fetch_cnt", {16'b0, fetch_cnt}, m_hs_cnt);
      chk("fault_cnt", {24'b0, fault_cnt}, m_flt_cnt);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; fault_ack = 1'b0; halt = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h08000293;
    mem[1] = 32'h04000313;

    // Reset values
    pmp_x_ok = 1'b1; out_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", {24'b0, out_pc}, 32'd0);
    chk("rst_fault_valid", {31'b0, fault_valid}, 32'd0);
    chk("rst_fault_pc", {24'b0, fault_pc}, 32'd0);
    chk("rst_imem_addr", {24'b0, imem_addr}, 32'd0);
    rst = 1'b0;

    // First two fetches
    step();
    chk("c1_valid", {31'b0, out_valid}, 32'd1);
    chk("c1_instr", out_instr, 32'h08000293);
    chk("c1_pc", {24'b0, out_pc}, 32'h00);
    step();
    chk("c2_instr", out_instr, 32'h04000313);
    chk("c2_pc", {24'b0, out_pc}, 32'h04);
    step();
    chk("c3_pc", {24'b0, out_pc}, 32'h08);

    // Backpressure holds outputs
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", {24'b0, out_pc}, 32'h08);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_addr", {24'b0, imem_addr}, 32'h0C);
    end
    out_ready = 1'b1;
    step();
    chk("release_pc", {24'b0, out_pc}, 32'h0C);

    // PMP fault at 0x24
    for (int i = 0; i < 5; i++) step();
    chk("pre_fault_pc", {24'b0, out_pc}, 32'h20);
    chk("pre_fault_addr", {24'b0, imem_addr}, 32'h24);
    pmp_x_ok = 1'b0;
    step();
    chk("pmp_fault_valid", {31'b0, fault_valid}, 32'd1);
    chk("pmp_fault_pc", {24'b0, fault_pc}, 32'h24);
    chk("pmp_out_valid", {31'b0, out_valid}, 32'd0);
    pmp_x_ok = 1'b1; fault_ack = 1'b1;
    step();
    chk("ack_fault_valid", {31'b0, fault_valid}, 32'd0);
    fault_ack = 1'b0;
    step();
    chk("parked_out_valid", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    step();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc", {24'b0, out_pc}, 32'h10);

    // Misaligned redirect faults; redirect beats simultaneous ack
    redirect_valid = 1'b1; redirect_pc = 8'h82;
    step();
    redirect_valid = 1'b0;
    step();
    chk("mis_fault_valid", {31'b0, fault_valid}, 32'd1);
    chk("mis_fault_pc", {24'b0, fault_pc}, 32'h82);
    redirect_valid = 1'b1; redirect_pc = 8'h00; fault_ack = 1'b1;
    step();
    chk("both_fault_valid", {31'b0, fault_valid}, 32'd0);
    redirect_valid = 1'b0; fault_ack = 1'b0;
    step();
    chk("both_out_pc", {24'b0, out_pc}, 32'h00);
    chk("both_out_valid", {31'b0, out_valid}, 32'd1);

    // PC wrap then halt
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_fc", {24'b0, out_pc}, 32'hFC);
    step();
    chk("wrap_00", {24'b0, out_pc}, 32'h00);
    halt = 1'b1;
    step();
    chk("halt_valid", {31'b0, out_valid}, 32'd0);
    chk("halt_instr", out_instr, NOP);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_addr", {24'b0, imem_addr}, 32'h04);
    end
    halt = 1'b0;
    step();
    chk("unhalt_pc", {24'b0, out_pc}, 32'h04);

    // Randomized traffic; the per-cycle compare does the checking
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63) * 4);
      halt           = ($urandom_range(0, 4) == 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      pmp_x_ok       = ($urandom_range(0, 9) != 0);
      fault_ack      = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    fault_ack = 1'b0; out_ready = 1'b1; pmp_x_ok = 1'b1;

`ifdef FETCH_STAT_EN
    // Counter values and saturation
    do_reset();
    for (int i = 0; i < 5; i++) step();
    pmp_x_ok = 1'b0;
    step();
    pmp_x_ok = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h02;
    step();
    redirect_valid = 1'b0;
    step();
    chk("stat_fetch_5", {16'b0, fetch_cnt}, 32'd5);
    chk("stat_fault_2", {24'b0, fault_cnt}, 32'd2);
    for (int i = 0; i < 300; i++) begin
      redirect_valid = 1'b1; redirect_pc = 8'h02;
      step();
      redirect_valid = 1'b0;
      step();
    end
    chk("stat_fault_sat", {24'b0, fault_cnt}, 32'hFF);
`else
    do_reset();
    step();
    chk("final_pc", {24'b0, out_pc}, 32'h00);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
